// File: rtl/eth_rx_frame_writer.sv
// MAC RX byte stream to frame-buffer port A: packs bytes into words, writes a
// circular buffer and publishes one descriptor per good frame.
module eth_rx_frame_writer #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 1024,
  parameter int MAX_BYTES = 1518,
  parameter int ADDR_W    = $clog2(RAM_DEPTH-1)
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  input  logic                 s_err,
  input  logic [ADDR_W:0]      rd_ptr,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [RAM_WIDTH-1:0] ram_din,
  output logic                 ram_we,
  output logic                 ram_en,
  output logic                 desc_valid,
  input  logic                 desc_ready,
  output logic [ADDR_W-1:0]    desc_addr,
  output logic [15:0]          desc_len,
  output logic [15:0]          drop_cnt
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [15:0]     MAX_LEN  = 16'(MAX_BYTES);

  state_t                 state, state_n;
  logic [ADDR_W:0]        wr_ptr, frm_start, start_n;
  logic [15:0]            byte_cnt, cnt_n;
  logic [RAM_WIDTH-1:0]   pack, word_n;
  logic [1:0]             lane;
  logic                   take, word_done, buf_full, slot_busy;
  logic                   drop, commit, write;
  logic                   commit_pend;
  logic [ADDR_W-1:0]      commit_addr;
  logic [15:0]            commit_len;

  assign ram_en = ram_we;

  always_comb begin
    take      = s_valid && (state != DROP);
    cnt_n     = (state == IDLE) ? 16'd1 : byte_cnt + 16'd1;
    start_n   = (state == IDLE) ? wr_ptr : frm_start;
    lane      = (state == IDLE) ? 2'd0 : byte_cnt[1:0];
    word_n    = ((lane == 2'd0) ? '0 : pack) | (RAM_WIDTH'(s_data) << {lane, 3'b000});
    word_done = (lane == 2'd3) || s_last;
    buf_full  = (wr_ptr - rd_ptr) == FULL_LVL;
    // A pending commit will occupy the slot next cycle, so it counts as busy.
    slot_busy = commit_pend || (desc_valid && !desc_ready);
    drop      = take && ((cnt_n > MAX_LEN) || (word_done && buf_full) ||
                         (s_last && (s_err || slot_busy)));
    commit    = take && s_last && !drop;
    write     = take && word_done && !drop;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, RECV: begin
        if (take) begin
          if (s_last)    state_n = IDLE;
          else if (drop) state_n = DROP;
          else           state_n = RECV;
        end
      end
      DROP: if (s_valid && s_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      wr_ptr      <= '0;
      frm_start   <= '0;
      byte_cnt    <= '0;
      pack        <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      drop_cnt    <= '0;
      commit_pend <= 1'b0;
      commit_addr <= '0;
      commit_len  <= '0;
      desc_valid  <= 1'b0;
      desc_addr   <= '0;
      desc_len    <= '0;
    end else begin
      ram_we <= write;
      if (write) begin
        ram_addr <= wr_ptr[ADDR_W-1:0];
        ram_din  <= word_n;
      end
      if (take && !drop) begin
        byte_cnt  <= cnt_n;
        frm_start <= start_n;
        pack      <= word_n;
      end
      if (drop)       wr_ptr <= start_n;
      else if (write) wr_ptr <= wr_ptr + 1'b1;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;

      // Descriptor lags the final word write by one cycle.
      commit_pend <= commit;
      if (commit) begin
        commit_addr <= start_n[ADDR_W-1:0];
        commit_len  <= cnt_n;
      end
      if (commit_pend) begin
        desc_valid <= 1'b1;
        desc_addr  <= commit_addr;
        desc_len   <= commit_len;
      end else if (desc_valid && desc_ready) begin
        desc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Directed bench for eth_rx_frame_writer: a 1024-word instance for framing,
// drop and descriptor rules, plus a 16-word instance for buffer overflow.
module tb_eth_rx_frame_writer;

  logic        clka = 1'b0;
  logic        rst_a, rst_b;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_err, desc_ready;

  logic [10:0] rd_ptr_a;
  logic [9:0]  ram_addr_a, desc_addr_a;
  logic [31:0] ram_din_a;
  logic        ram_we_a, ram_en_a, desc_valid_a;
  logic [15:0] desc_len_a, drop_cnt_a;

  logic [4:0]  rd_ptr_b;
  logic [3:0]  ram_addr_b, desc_addr_b;
  logic [31:0] ram_din_b;
  logic        ram_we_b, ram_en_b, desc_valid_b;
  logic [15:0] desc_len_b, drop_cnt_b;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:15];
  int          wcnt_a = 0, wcnt_b = 0, w0;
  int          n_checks = 0, n_fail = 0;

  always #5 clka = ~clka;

  eth_rx_frame_writer #(.RAM_DEPTH(1024), .MAX_BYTES(1518)) dut_a (
    .clka(clka), .rsta(rst_a), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_err(s_err), .rd_ptr(rd_ptr_a), .ram_addr(ram_addr_a),
    .ram_din(ram_din_a), .ram_we(ram_we_a), .ram_en(ram_en_a),
    .desc_valid(desc_valid_a), .desc_ready(desc_ready), .desc_addr(desc_addr_a),
    .desc_len(desc_len_a), .drop_cnt(drop_cnt_a)
  );

  eth_rx_frame_writer #(.RAM_DEPTH(16), .MAX_BYTES(1518)) dut_b (
    .clka(clka), .rsta(rst_b), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_err(s_err), .rd_ptr(rd_ptr_b), .ram_addr(ram_addr_b),
    .ram_din(ram_din_b), .ram_we(ram_we_b), .ram_en(ram_en_b),
    .desc_valid(desc_valid_b), .desc_ready(desc_ready), .desc_addr(desc_addr_b),
    .desc_len(desc_len_b), .drop_cnt(drop_cnt_b)
  );

  always @(posedge clka) begin
    if (ram_we_a) begin
      mem_a[ram_addr_a] <= ram_din_a;
      wcnt_a <= wcnt_a + 1;
    end
    if (ram_we_b) begin
      mem_b[ram_addr_b] <= ram_din_b;
      wcnt_b <= wcnt_b + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bytes first, first+1, ...; returns on the negedge after the last byte is taken.
  task automatic send_frame(input int unsigned len, input logic [7:0] first,
                            input logic err, input logic last_en);
    for (int unsigned i = 0; i < len; i++) begin
      @(negedge clka);
      s_valid = 1'b1;
      s_data  = 8'(first + i[7:0]);
      s_last  = last_en && (i == len - 1);
      s_err   = err && (i == len - 1);
    end
    @(negedge clka);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_err   = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0;
    desc_ready = 1'b1; rd_ptr_a = '0; rd_ptr_b = '0;
    repeat (3) @(negedge clka);
    check("rst_ram_we",     ram_we_a,     0);
    check("rst_ram_en",     ram_en_a,     0);
    check("rst_desc_valid", desc_valid_a, 0);
    check("rst_drop_cnt",   drop_cnt_a,   0);
    check("rst_ram_addr",   ram_addr_a,   0);
    check("rst_ram_din",    ram_din_a,    0);
    rst_a = 1'b0;
    @(negedge clka);

    // 8-byte good frame
    send_frame(8, 8'h01, 1'b0, 1'b1);
    check("f1_we",          ram_we_a,     1);
    check("f1_last_addr",   ram_addr_a,   1);
    check("f1_dv_early",    desc_valid_a, 0);
    @(negedge clka);
    check("f1_dv",          desc_valid_a, 1);
    check("f1_daddr",       desc_addr_a,  0);
    check("f1_dlen",        desc_len_a,   8);
    check("f1_w0",          mem_a[0],     32'h04030201);
    check("f1_w1",          mem_a[1],     32'h08070605);

    // 5-byte frame with partial final word
    send_frame(5, 8'hA1, 1'b0, 1'b1);
    check("f2_addr",        ram_addr_a,   3);
    check("f2_din",         ram_din_a,    32'h000000A5);
    @(negedge clka);
    check("f2_dv",          desc_valid_a, 1);
    check("f2_daddr",       desc_addr_a,  2);
    check("f2_dlen",        desc_len_a,   5);
    check("f2_w2",          mem_a[2],     32'hA4A3A2A1);

    // errored frame, then good frame reusing its start address
    send_frame(6, 8'h10, 1'b1, 1'b1);
    check("err_we",         ram_we_a,     0);
    check("err_drop_cnt",   drop_cnt_a,   1);
    @(negedge clka);
    check("err_no_desc",    desc_valid_a, 0);
    send_frame(4, 8'hB0, 1'b0, 1'b1);
    check("f3_addr",        ram_addr_a,   4);
    check("f3_din",         ram_din_a,    32'hB3B2B1B0);
    @(negedge clka);
    check("f3_daddr",       desc_addr_a,  4);
    check("f3_dlen",        desc_len_a,   4);

    // oversize 1600-byte frame, then a maximum 1518-byte frame at the same start
    w0 = wcnt_a;
    send_frame(1600, 8'h00, 1'b0, 1'b1);
    @(negedge clka);
    check("big_drop_cnt",   drop_cnt_a,   2);
    check("big_no_desc",    desc_valid_a, 0);
    send_frame(1518, 8'h03, 1'b0, 1'b1);
    check("max_last_addr",  ram_addr_a,   384);
    check("max_last_din",   ram_din_a,    32'h0000F0EF);
    @(negedge clka);
    check("max_dv",         desc_valid_a, 1);
    check("max_daddr",      desc_addr_a,  5);
    check("max_dlen",       desc_len_a,   1518);
    check("max_w5",         mem_a[5],     32'h06050403);
    check("big_word_count", wcnt_a - w0,  759);

    // overflow on the 16-word instance with the reader parked at 0
    rst_b = 1'b0;
    @(negedge clka);
    send_frame(70, 8'h40, 1'b0, 1'b1);
    repeat (2) @(negedge clka);
    check("ovf_writes",     wcnt_b,       16);
    check("ovf_drop_cnt",   drop_cnt_b,   1);
    check("ovf_no_desc",    desc_valid_b, 0);
    check("ovf_w0",         mem_b[0],     32'h43424140);
    check("ovf_w15",        mem_b[15],    32'h7F7E7D7C);
    send_frame(4, 8'hE0, 1'b0, 1'b1);
    check("ovf_rewind_addr", ram_addr_b,  0);
    @(negedge clka);
    check("ovf_next_dv",    desc_valid_b, 1);
    check("ovf_next_daddr", desc_addr_b,  0);
    check("ovf_next_dlen",  desc_len_b,   4);

    // occupied descriptor slot
    rst_a = 1'b1;
    @(negedge clka);
    rst_a = 1'b0;
    desc_ready = 1'b0;
    send_frame(4, 8'hD0, 1'b0, 1'b1);
    check("hold_din",       ram_din_a,    32'hD3D2D1D0);
    @(negedge clka);
    check("hold_dv",        desc_valid_a, 1);
    send_frame(4, 8'hF0, 1'b0, 1'b1);
    check("busy_we",        ram_we_a,     0);
    check("busy_drop_cnt",  drop_cnt_a,   1);
    repeat (3) @(negedge clka);
    check("busy_dv_held",   desc_valid_a, 1);
    check("busy_daddr",     desc_addr_a,  0);
    check("busy_dlen",      desc_len_a,   4);

    // asynchronous reset mid-frame
    send_frame(3, 8'h55, 1'b0, 1'b0);
    #2 rst_a = 1'b1;
    #1;
    check("arst_dv",        desc_valid_a, 0);
    check("arst_drop_cnt",  drop_cnt_a,   0);
    check("arst_dlen",      desc_len_a,   0);
    check("arst_ram_din",   ram_din_a,    0);
    check("arst_ram_en",    ram_en_a,     0);
    @(negedge clka);
    rst_a = 1'b0;
    @(negedge clka);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_writer.md
Name: eth_rx_frame_writer

Overview:
- Receive-side frame writer between the Ethernet MAC RX byte stream and port A of the dual-port frame buffer RAM.
- Packs bytes little-endian into RAM_WIDTH-bit words and writes them into a circular buffer.
- Commits good frames as a descriptor (start word address, byte length) to the downstream reader, which drains the buffer through port B.
- Rewinds the write pointer on bad, oversized or overflowing frames, so no partial frame is ever visible downstream.

Parameters:
- RAM_WIDTH, 32, buffer word width; fixed at 32 (4 bytes/word).
- RAM_DEPTH, 1024, buffer depth in words; must be a power of two.
- MAX_BYTES, 1518, largest accepted frame in bytes; longer frames are dropped.
- ADDR_W, $clog2(RAM_DEPTH-1), word address width, matching the RAM address port.

Ports:
- clka  in  1  clock; shared with RAM port A.
- rsta  in  1  reset, asynchronous, active-high.
- s_data  in  8  RX byte.
- s_valid  in  1  byte valid; no backpressure, a byte is taken every valid cycle.
- s_last  in  1  final byte of frame; qualified by s_valid.
- s_err  in  1  frame error (FCS/PHY); sampled with s_last.
- rd_ptr  in  ADDR_W+1  reader's free pointer in words; extra MSB is the wrap bit.
- ram_addr  out  ADDR_W  RAM port A address.
- ram_din  out  RAM_WIDTH  RAM port A write data.
- ram_we  out  1  RAM port A write enable.
- ram_en  out  1  RAM port A enable; equals ram_we.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  reader accepts descriptor.
- desc_addr  out  ADDR_W  first word address of the frame.
- desc_len  out  16  frame length in bytes.
- drop_cnt  out  16  count of dropped frames; saturates at 0xFFFF.

Behaviour:
Reset (rsta high, asynchronous):
- State IDLE; wr_ptr, frm_start, byte_cnt = 0.
- ram_we, ram_en, desc_valid = 0; ram_addr, ram_din, desc_addr, desc_len, drop_cnt = 0.
- The pack register is cleared.

States:
- IDLE: first s_valid byte sets frm_start = wr_ptr and byte_cnt = 1, then goes to RECV. A single-byte frame (s_last on that byte) is finalised immediately.
- RECV: each s_valid byte increments byte_cnt.
- DROP: discards bytes until s_valid & s_last, then returns to IDLE. Nothing is written.

Packing:
- Byte k of a word goes to bits [8k+7:8k].
- After the 4th byte, or on s_last with a partial word, the word is registered to the RAM: ram_we = 1 for exactly one cycle, on the cycle after the completing byte.
- Unused upper bytes of a partial word are 0.
- wr_ptr (ADDR_W+1 bits) increments per written word. ram_addr = wr_ptr[ADDR_W-1:0] and wraps modulo RAM_DEPTH.

Overflow:
- Before each word write the block checks wr_ptr - rd_ptr (mod 2^(ADDR_W+1)).
- If it equals RAM_DEPTH (buffer full), no write occurs and the frame is dropped.

Drop conditions:
- Buffer full (above).
- byte_cnt would exceed MAX_BYTES.
- s_err = 1 with s_last.
- Commit while desc_valid = 1 and desc_ready = 0 (descriptor slot occupied).

Drop action:
- wr_ptr is restored to frm_start.
- drop_cnt increments (saturating).
- Next state is DROP, or IDLE if the dropping byte had s_last.

Commit (good s_last at cycle N):
- The final word is written at the end of cycle N+1.
- desc_valid rises in cycle N+2 with desc_addr = frm_start[ADDR_W-1:0] and desc_len = byte_cnt.
- desc_valid and its fields are held stable until desc_ready.
- The descriptor is consumed on desc_valid & desc_ready, and desc_valid falls on the next cycle unless a new commit lands in the same cycle; in that case the new descriptor loads.

Other rules:
- Back-to-back frames: the next frame may start on the cycle after s_last.
- Frame length is never 0.
- Reset asserted mid-frame discards the frame silently (no drop_cnt increment); the buffer is treated as empty afterwards.

Test Plan:
- Reset, 8-byte good frame 0x01..0x08 -> words 0x04030201 @0 and 0x08070605 @1; desc_addr=0, desc_len=8, desc_valid 2 cycles after s_last.
- 5-byte frame 0xA1..0xA5 after it -> word @2 = 0xA4A3A2A1, @3 = 0x000000A5; desc_addr=2, desc_len=5.
- Frame with s_err=1 on last -> no descriptor; drop_cnt=1; next good frame starts at the dropped frame's start address.
- 1600-byte frame -> dropped at byte 1519; remaining bytes ignored; drop_cnt increments; wr_ptr restored.
- RAM_DEPTH=16, rd_ptr held at 0, 70-byte frame -> overflow on 17th word; dropped; no write to address 0 after wrap.
- desc_ready held 0, two good frames -> first descriptor held stable, second dropped (drop_cnt=1); first descriptor still valid; rsta pulse mid-frame -> all outputs return to 0 immediately.
